// File: rtl/sram_arbiter_pkg.sv
// Shared types and default geometry for the SRAM arbiter and its data pad.
// Strobe levels are named so the FSM reads in terms of enable/disable.
package sram_arbiter_pkg;

  localparam int CPU_AW_DEF    = 16;
  localparam int SRAM_AW_DEF   = 18;
  localparam int DW_DEF        = 16;
  localparam int WE_CYCLES_DEF = 1;

  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEM_RD,
    ST_IF_RD,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD
  } state_t;

  // Narrowest counter able to index WE_CYCLES pulse cycles (never zero-width).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_pad.sv
// Tristate driver and input path for the bidirectional SRAM data bus.
module sram_pad import sram_arbiter_pkg::*; #(
  parameter int DW = DW_DEF
) (
  input  logic          i_drive,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata,
  inout  wire  [DW-1:0] io_data
);

  assign io_data = i_drive ? i_wdata : {DW{1'bz}};
  assign o_rdata = io_data;

endmodule

// File: rtl/sram_arbiter.sv
// Owns the shared asynchronous SRAM: MEM has priority, IF is served when MEM is idle.
// All strobes and ready pulses are registered; only the stall is combinational.
module sram_arbiter import sram_arbiter_pkg::*; #(
  parameter int CPU_AW    = CPU_AW_DEF,
  parameter int SRAM_AW   = SRAM_AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int WE_CYCLES = WE_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req_i,
  input  logic [CPU_AW-1:0]  if_addr_i,
  output logic [DW-1:0]      if_data_o,
  output logic               if_ready_o,
  input  logic               mem_rd_i,
  input  logic               mem_wr_i,
  input  logic [CPU_AW-1:0]  mem_addr_i,
  input  logic [DW-1:0]      mem_wdata_i,
  output logic [DW-1:0]      mem_rdata_o,
  output logic               mem_ready_o,
  output logic               stall_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  inout  wire  [DW-1:0]      sram_data_io,
  output logic               sram_ce_n_o,
  output logic               sram_oe_n_o,
  output logic               sram_we_n_o
);

  localparam int            CW       = cnt_width(WE_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(WE_CYCLES - 1);

  state_t              r_state;
  logic [SRAM_AW-1:0]  r_addr;
  logic [DW-1:0]       r_wdata;
  logic [DW-1:0]       r_if_data;
  logic [DW-1:0]       r_mem_rdata;
  logic                r_ce_n;
  logic                r_oe_n;
  logic                r_we_n;
  logic                r_drive;
  logic                r_if_ready;
  logic                r_mem_ready;
  logic [CW-1:0]       r_we_cnt;
  logic [DW-1:0]       w_pad_rdata;

  sram_pad #(.DW(DW)) u_pad (
    .i_drive (r_drive),
    .i_wdata (r_wdata),
    .o_rdata (w_pad_rdata),
    .io_data (sram_data_io)
  );

  // Reset drops every strobe at once so an interrupted write cannot corrupt the SRAM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_if_data   <= '0;
      r_mem_rdata <= '0;
      r_ce_n      <= STROBE_OFF;
      r_oe_n      <= STROBE_OFF;
      r_we_n      <= STROBE_OFF;
      r_drive     <= 1'b0;
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      r_we_cnt    <= '0;
    end else begin
      r_if_ready  <= 1'b0;
      r_mem_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (mem_wr_i) begin
            r_state <= ST_WR_SETUP;
            r_addr  <= SRAM_AW'(mem_addr_i);
            r_wdata <= mem_wdata_i;
            r_ce_n  <= STROBE_ON;
            r_drive <= 1'b1;
          end else if (mem_rd_i) begin
            r_state <= ST_MEM_RD;
            r_addr  <= SRAM_AW'(mem_addr_i);
            r_ce_n  <= STROBE_ON;
            r_oe_n  <= STROBE_ON;
          end else if (if_req_i) begin
            r_state <= ST_IF_RD;
            r_addr  <= SRAM_AW'(if_addr_i);
            r_ce_n  <= STROBE_ON;
            r_oe_n  <= STROBE_ON;
          end
        end
        ST_MEM_RD: begin
          r_mem_rdata <= w_pad_rdata;
          r_mem_ready <= 1'b1;
          r_ce_n      <= STROBE_OFF;
          r_oe_n      <= STROBE_OFF;
          r_state     <= ST_IDLE;
        end
        ST_IF_RD: begin
          r_if_data  <= w_pad_rdata;
          r_if_ready <= 1'b1;
          r_ce_n     <= STROBE_OFF;
          r_oe_n     <= STROBE_OFF;
          r_state    <= ST_IDLE;
        end
        ST_WR_SETUP: begin
          r_we_n   <= STROBE_ON;
          r_we_cnt <= '0;
          r_state  <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          if (r_we_cnt == LAST_CNT) begin
            r_we_n   <= STROBE_OFF;
            r_we_cnt <= '0;
            r_state  <= ST_WR_HOLD;
          end else begin
            r_we_cnt <= r_we_cnt + 1'b1;
          end
        end
        ST_WR_HOLD: begin
          r_ce_n      <= STROBE_OFF;
          r_drive     <= 1'b0;
          r_mem_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign if_data_o   = r_if_data;
  assign if_ready_o  = r_if_ready;
  assign mem_rdata_o = r_mem_rdata;
  assign mem_ready_o = r_mem_ready;
  assign sram_addr_o = r_addr;
  assign sram_ce_n_o = r_ce_n;
  assign sram_oe_n_o = r_oe_n;
  assign sram_we_n_o = r_we_n;

  // Ready in the same cycle releases the stall so the pipeline advances on it.
  assign stall_o = ((mem_rd_i | mem_wr_i) & ~r_mem_ready) | (if_req_i & ~r_if_ready);

endmodule
